switch_allocator: RTL

- Per-output wormhole switch allocator for the router crossbar.
- Each input port posts one request per cycle: valid, target output, and a tail marker. The allocator arbitrates round-robin per output and drives the crossbar select lines `sel_o` plus per-output valids.
- An output stays locked to the winning input from the head flit until that input's tail flit transfers.
- Sits between the input-buffer/route-compute stage and the crossbar.

---
 rtl/switch_allocator.sv | 96 +++++++++
 1 files changed

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin wormhole allocator driving crossbar selects; SA_WATCHDOG_EN adds stalled-lock watchdog err_o
module switch_allocator #(
  parameter int INPUT_NUM = 5,
  parameter int OUTPUT_NUM = 5,
`ifdef SA_WATCHDOG_EN
  parameter int WDOG_CYCLES = 64,
`endif
  localparam int SEL_SIZE = ($clog2(INPUT_NUM) > 1) ? $clog2(INPUT_NUM) : 1,
  localparam int OSEL_SIZE = ($clog2(OUTPUT_NUM) > 1) ? $clog2(OUTPUT_NUM) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [INPUT_NUM-1:0]             req_valid_i,
  input  logic [INPUT_NUM*OSEL_SIZE-1:0]   req_port_i,
  input  logic [INPUT_NUM-1:0]             req_tail_i,
  input  logic [OUTPUT_NUM-1:0]            out_ready_i,
  output logic [OUTPUT_NUM*SEL_SIZE-1:0]   sel_o,
  output logic [OUTPUT_NUM-1:0]            out_valid_o,
  output logic [INPUT_NUM-1:0]             grant_o
`ifdef SA_WATCHDOG_EN
  ,
  output logic [OUTPUT_NUM-1:0]            err_o
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t              r_state [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] r_owner [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] r_ptr   [OUTPUT_NUM];
  logic [SEL_SIZE-1:0] w_win   [OUTPUT_NUM];
  logic [INPUT_NUM-1:0] w_req  [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] w_xfer, w_tail;
  // pick the owner (locked) or the first requester from ptr (idle); scanning backwards lets the earliest match win
  always_comb begin
    sel_o = '0;
    out_valid_o = '0;
    grant_o = '0;
    w_xfer = '0;
    w_tail = '0;
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      w_win[j] = '0;
      w_req[j] = '0;
      for (int i = 0; i < INPUT_NUM; i++)
        w_req[j][i] = req_valid_i[i] && (req_port_i[i*OSEL_SIZE +: OSEL_SIZE] == OSEL_SIZE'(j));
      if (r_state[j] == LOCKED) begin
        w_win[j] = r_owner[j];
        out_valid_o[j] = w_req[j][r_owner[j]];
      end else begin
        for (int k = INPUT_NUM - 1; k >= 0; k--)
          if (w_req[j][(int'(r_ptr[j]) + k) % INPUT_NUM]) begin
            w_win[j] = SEL_SIZE'((int'(r_ptr[j]) + k) % INPUT_NUM);
            out_valid_o[j] = 1'b1;
          end
      end
      sel_o[j*SEL_SIZE +: SEL_SIZE] = w_win[j];
      w_xfer[j] = out_valid_o[j] && out_ready_i[j];
      w_tail[j] = req_tail_i[w_win[j]];
      if (w_xfer[j]) grant_o[w_win[j]] = 1'b1;
    end
  end
  // lock on a head transfer, release and advance the pointer past the sender on a tail transfer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        r_state[j] <= IDLE;
        r_owner[j] <= '0;
        r_ptr[j] <= '0;
      end
    end else begin
      for (int j = 0; j < OUTPUT_NUM; j++)
        if (w_xfer[j]) begin
          r_state[j] <= w_tail[j] ? IDLE : LOCKED;
          r_owner[j] <= w_win[j];
          if (w_tail[j]) r_ptr[j] <= (w_win[j] == SEL_SIZE'(INPUT_NUM - 1)) ? '0 : w_win[j] + 1'b1;
        end
    end
  end
`ifdef SA_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] r_wcnt [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] r_err;
  assign err_o = r_err;
  // count consecutive stalled locked cycles per output; the error flag is sticky until reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= '0;
      for (int j = 0; j < OUTPUT_NUM; j++) r_wcnt[j] <= '0;
    end else begin
      for (int j = 0; j < OUTPUT_NUM; j++)
        if (r_state[j] == LOCKED && !w_xfer[j]) begin
          if (r_wcnt[j] != WCW'(WDOG_CYCLES)) r_wcnt[j] <= r_wcnt[j] + 1'b1;
          if (r_wcnt[j] >= WCW'(WDOG_CYCLES - 1)) r_err[j] <= 1'b1;
        end else r_wcnt[j] <= '0;
    end
  end
`endif
endmodule
